palindrome_arbiter: RTL and testbench

PALINDROME_ARBITER -- requirements
Module: palindrome_arbiter

---
 rtl/palindrome_arbiter.sv | 114 +++++++++++
 tb/tb_palindrome_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/palindrome_arbiter.sv
// palindrome_arbiter
//   Round-robin arbiter over NUM_REQ requesters. The winner's operand is
//   captured, checked for bit-reversal symmetry, and the result is presented
//   on a valid/ready response port. Statistics counters track completed
//   responses and palindromic ones; both saturate.
// Ports
//   clk, rst_n           : clock, synchronous active-low reset
//   req, data_in         : per-requester request bit and packed operand bus
//   gnt                  : one-hot single-cycle accept pulse (combinational)
//   rsp_valid/rsp_ready  : response handshake
//   rsp_id               : index of the requester whose result is presented
//   rsp_palindrome       : 1 when the operand equals its bit reversal
//   busy                 : FSM not in IDLE
//   total_cnt, pal_cnt   : saturating response / palindrome counters
module palindrome_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] data_in,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [1:0]               rsp_id,
  output logic                     rsp_palindrome,
  output logic                     busy,
  output logic [CNT_W-1:0]         total_cnt,
  output logic [CNT_W-1:0]         pal_cnt
);

  typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

  state_t                          state, nxt;
  logic [1:0]                      ptr;
  logic [1:0]                      id;
  logic [WIDTH-1:0]                operand;
  logic [WIDTH-1:0]                rev;
  logic                            pal_q;
  logic [NUM_REQ-1:0][WIDTH-1:0]   lane_data;
  logic [1:0]                      win;
  logic [1:0]                      idx;
  logic                            found;
  logic                            gnt_en;
  logic                            hs;

  assign lane_data = data_in;

  // Bit reversal of the captured operand.
  for (genvar j = 0; j < WIDTH; j++) begin : g_rev
    assign rev[j] = operand[WIDTH-1-j];
  end

  // Round-robin search starting at ptr; first pending requester wins.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign gnt_en = rst_n && (state == IDLE) && found;
  assign gnt    = gnt_en ? (NUM_REQ'(1) << win) : '0;
  assign hs     = (state == RESP) && rsp_ready;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (|req) nxt = CHECK;
      CHECK:   nxt = RESP;
      RESP:    if (rsp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      id        <= '0;
      operand   <= '0;
      pal_q     <= 1'b0;
      total_cnt <= '0;
      pal_cnt   <= '0;
    end else begin
      state <= nxt;
      if (gnt_en) begin
        operand <= lane_data[win];
        id      <= win;
      end
      if (state == CHECK) pal_q <= (operand == rev);
      if (hs) begin
        // Next search starts just after the requester that was served.
        ptr <= id + 2'd1;
        if (total_cnt != '1) total_cnt <= total_cnt + CNT_W'(1);
        if (pal_q && (pal_cnt != '1)) pal_cnt <= pal_cnt + CNT_W'(1);
      end
    end
  end

  assign rsp_valid      = (state == RESP);
  assign busy           = (state != IDLE);
  assign rsp_id         = id;
  assign rsp_palindrome = pal_q;

endmodule

// File: tb/tb_palindrome_arbiter.sv
// Bench for palindrome_arbiter: the stimulus side predicts grants from a
// transaction-level model and pushes expected responses into a scoreboard;
// an independent monitor pops and compares whenever rsp_valid is seen.
// CNT_W is reduced so counter saturation is reachable in a short run.
module tb_palindrome_arbiter;
  localparam int NR    = 4;
  localparam int W     = 8;
  localparam int CNT_W = 10;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NR-1:0]       req;
  logic [NR*W-1:0]     data_in;
  logic [NR-1:0]       gnt;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [1:0]          rsp_id;
  logic                rsp_palindrome;
  logic                busy;
  logic [CNT_W-1:0]    total_cnt;
  logic [CNT_W-1:0]    pal_cnt;

  palindrome_arbiter #(.NUM_REQ(NR), .WIDTH(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_palindrome(rsp_palindrome), .busy(busy),
    .total_cnt(total_cnt), .pal_cnt(pal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int id; bit pal; int gcyc; } exp_t;
  exp_t sb[$];
  exp_t cur;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  bit armed = 0;
  bit have = 0;
  int mptr = 0;          // model round-robin pointer (monitor-owned)
  int done_cnt = 0;      // responses completed (monitor-owned)
  int idle_from = 0;     // first idle cycle after last handshake (monitor)
  int grant_cnt = 0;     // grants issued (stimulus-owned)
  int rst_from = 0;      // first idle cycle after a reset (stimulus)
  int exp_rsp_cyc = -1;
  int exp_tot = 0, exp_pal = 0;
  int last_gnt;
  int gorder[$];

  // stimulus-side requester model
  logic [NR-1:0] pend;
  logic [W-1:0]  pdata [NR];
  logic          rstn_v, rdy;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic bit is_pal(input logic [W-1:0] d);
    for (int j = 0; j < W; j++) if (d[j] !== d[W-1-j]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [W-1:0] pal_byte();
    logic [W-1:0] d;
    logic [31:0]  r;
    r = $urandom;
    d = '0;
    for (int j = 0; j < W/2; j++) begin
      d[j]     = r[j];
      d[W-1-j] = r[j];
    end
    return d;
  endfunction

  function automatic bit model_idle();
    return (grant_cnt == done_cnt) && (cyc >= idle_from) && (cyc >= rst_from);
  endfunction

  // One clock: drive inputs after the rising edge, check gnt at the falling edge.
  task automatic tick();
    logic [NR-1:0] eg;
    int w;
    bit f;
    @(posedge clk); #1;
    rst_n     = rstn_v;
    rsp_ready = rdy;
    req       = pend;
    for (int i = 0; i < NR; i++) data_in[i*W +: W] = pdata[i];
    @(negedge clk);
    eg = '0; w = 0; f = 0; last_gnt = -1;
    if (rstn_v && model_idle() && (pend != '0)) begin
      for (int k = 0; k < NR; k++) begin
        if (!f && pend[(mptr + k) % NR]) begin
          f = 1; w = (mptr + k) % NR;
        end
      end
      eg[w] = 1'b1;
    end
    chk("gnt", gnt, eg);
    if (armed) chk("busy", busy, !model_idle());
    if (cyc == exp_rsp_cyc) chk("rsp_valid_latency", rsp_valid, 1);
    if (!rstn_v) begin
      sb.delete();
      grant_cnt   = done_cnt;
      rst_from    = cyc + 1;
      exp_rsp_cyc = -1;
    end else if (f) begin
      sb.push_back('{w, is_pal(pdata[w]), cyc});
      grant_cnt++;
      pend[w]     = 1'b0;
      exp_rsp_cyc = cyc + 2;
      last_gnt    = w;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || have || !model_idle()) && n < 50) begin
      tick();
      n++;
    end
    chk("drain_done", n < 50, 1);
  endtask

  task automatic do_reset();
    rstn_v = 0; tick();
    rstn_v = 1; tick();
  endtask

  // Monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (armed) begin
      chk("total_cnt", total_cnt, exp_tot);
      chk("pal_cnt", pal_cnt, exp_pal);
      if (!rst_n) begin
        have = 0; exp_tot = 0; exp_pal = 0; mptr = 0;
      end else if (rsp_valid) begin
        if (!have) begin
          if (sb.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
          else begin
            cur  = sb.pop_front();
            have = 1;
            chk("rsp_first_cycle", cyc, cur.gcyc + 2);
          end
        end
        if (have) begin
          chk("rsp_id", rsp_id, cur.id);
          chk("rsp_palindrome", rsp_palindrome, cur.pal);
          if (rsp_ready) begin
            if (exp_tot < MAXC) exp_tot++;
            if (cur.pal && exp_pal < MAXC) exp_pal++;
            mptr      = (cur.id + 1) % NR;
            idle_from = cyc + 1;
            done_cnt++;
            have = 0;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; req = '0; data_in = '0; rsp_ready = 0;
    rstn_v = 0; rdy = 0; pend = '0;
    for (int i = 0; i < NR; i++) pdata[i] = '0;
    tick(); tick();
    armed = 1;
    rstn_v = 1;
    tick();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_pal", rsp_palindrome, 0);
    chk("rst_total", total_cnt, 0);
    chk("rst_pal", pal_cnt, 0);

    // single palindrome request
    rdy = 1; pend[0] = 1; pdata[0] = 8'h81;
    tick(); chk("single_gnt", last_gnt, 0);
    drain();
    chk("single_total", total_cnt, 1);
    chk("single_pal", pal_cnt, 1);

    // non-palindrome from requester 2
    pend[2] = 1; pdata[2] = 8'h12;
    tick(); chk("nonpal_gnt", last_gnt, 2);
    drain();
    chk("nonpal_total", total_cnt, 2);
    chk("nonpal_pal", pal_cnt, 1);

    // round-robin fairness with all requests held
    do_reset();
    pdata[0] = 8'hA5; pdata[1] = 8'h01; pdata[2] = 8'h3C; pdata[3] = 8'h18;
    pend = 4'hF;
    for (int n = 0; n < 40 && gorder.size() < 5; n++) begin
      tick();
      if (last_gnt >= 0) gorder.push_back(last_gnt);
      pend = (gorder.size() < 5) ? 4'hF : 4'h0;
    end
    pend = '0;
    drain();
    chk("rr_count", gorder.size(), 5);
    for (int g = 0; g < gorder.size() && g < 5; g++) chk("rr_order", gorder[g], g % 4);
    chk("rr_total", total_cnt, 5);
    chk("rr_pal", pal_cnt, 4);

    // backpressure: hold rsp_ready low for 5 RESP cycles
    rdy = 0; pend[1] = 1; pdata[1] = pal_byte(); pend[3] = 1; pdata[3] = 8'h5A;
    tick(); chk("bp_gnt", last_gnt, 1);
    tick();
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("bp_valid", rsp_valid, 1);
      chk("bp_busy", busy, 1);
      chk("bp_no_gnt", gnt, 0);
    end
    rdy = 1;
    tick();
    tick(); chk("bp_done_total", total_cnt, 6); chk("bp_next_gnt", last_gnt, 3);
    pend = '0;
    drain();

    // reset during CHECK aborts the operation
    pend[3] = 1; pdata[3] = 8'hFF;
    tick(); chk("abort_gnt", last_gnt, 3);
    rstn_v = 0; tick();
    rstn_v = 1; tick();
    chk("abort_valid", rsp_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_total", total_cnt, 0);
    chk("abort_pal", pal_cnt, 0);
    pend = 4'b1010; pdata[1] = 8'h3C; pdata[3] = 8'h01;
    tick(); chk("abort_next_gnt", last_gnt, 1);
    pend = '0;
    drain();

    // randomized traffic with random backpressure
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NR; i++)
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i]  = 1;
          pdata[i] = $urandom_range(0, 1) ? pal_byte() : W'($urandom);
        end
      rdy = ($urandom_range(0, 3) != 0);
      tick();
    end
    pend = '0; rdy = 1;
    drain();

    // counter saturation
    do_reset();
    for (int n = 0; n <= MAXC; n++) begin
      pend[$urandom_range(0, NR-1)] = 1;
      for (int i = 0; i < NR; i++) pdata[i] = pal_byte();
      tick();
      pend = '0;
      drain();
    end
    pend[0] = 1; pdata[0] = 8'hFF;
    tick(); pend = '0;
    drain();
    chk("sat_total", total_cnt, MAXC);
    chk("sat_pal", pal_cnt, MAXC);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
